// File: rtl/dpram_be_clr.sv
// ============================================================================
// Module   : dpram_be_clr
// Brief    : Single-clock true dual-port RAM with byte enables, selectable
//            read-during-write, optional output register and clear sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dpram_be_clr #(
    parameter int                 WIDTH       = 8,
    parameter int                 ADDR_BITS   = 16,
    parameter int                 OUTREG      = 0,
    parameter int                 RDW_MODE    = 0,
    parameter logic [WIDTH-1:0]   CLEAR_VALUE = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    output logic                   busy,
    input  logic [ADDR_BITS-1:0]   address_a,
    input  logic [WIDTH-1:0]       data_a,
    input  logic                   wren_a,
    input  logic [WIDTH/8-1:0]     byteena_a,
    output logic [WIDTH-1:0]       q_a,
    input  logic [ADDR_BITS-1:0]   address_b,
    input  logic [WIDTH-1:0]       data_b,
    input  logic                   wren_b,
    input  logic [WIDTH/8-1:0]     byteena_b,
    output logic [WIDTH-1:0]       q_b,
    output logic                   collision
);

    localparam int         c_BYTES    = WIDTH / 8;
    localparam int         c_DEPTH    = 2 ** ADDR_BITS;
    localparam bit         c_RDW_OLD  = (RDW_MODE != 0);
    localparam logic [ADDR_BITS:0] c_CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    logic [WIDTH-1:0]     r_mem [c_DEPTH];

    state_t               r_state_q, w_state_d;
    logic [ADDR_BITS:0]   r_cnt_q, w_cnt_d;
    logic [WIDTH-1:0]     r_qa_q, w_qa_d;
    logic [WIDTH-1:0]     r_qb_q, w_qb_d;
    logic                 r_coll_q, w_coll_d;

    logic                 w_ready;
    logic                 w_clr_we;
    logic                 w_we_a, w_we_b;
    logic [WIDTH-1:0]     w_old_a, w_old_b;
    logic [WIDTH-1:0]     w_merge_a, w_merge_b;

    assign w_ready  = (r_state_q == S_READY) && !reset;
    assign w_clr_we = (r_state_q == S_CLEAR) && !reset;
    assign w_we_a   = w_ready && wren_a;
    assign w_we_b   = w_ready && wren_b;

    assign w_old_a  = r_mem[address_a];
    assign w_old_b  = r_mem[address_b];

    always_comb begin
        w_merge_a = w_old_a;
        w_merge_b = w_old_b;
        for (int i = 0; i < c_BYTES; i++) begin
            if (byteena_a[i]) w_merge_a[8*i +: 8] = data_a[8*i +: 8];
            if (byteena_b[i]) w_merge_b[8*i +: 8] = data_b[8*i +: 8];
        end
    end

    // Port A is written last so it owns any byte both ports enable.
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[r_cnt_q[ADDR_BITS-1:0]] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < c_BYTES; i++) begin
                if (w_we_b && byteena_b[i]) r_mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
            end
            for (int i = 0; i < c_BYTES; i++) begin
                if (w_we_a && byteena_a[i]) r_mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_qa_d    = '0;
        w_qb_d    = '0;
        w_coll_d  = 1'b0;
        if (r_state_q == S_CLEAR) begin
            w_cnt_d = r_cnt_q + c_CNT_ONE;
            if (w_cnt_d[ADDR_BITS]) w_state_d = S_READY;
        end else begin
            if (clear) begin
                w_state_d = S_CLEAR;
                w_cnt_d   = '0;
            end
            w_qa_d   = (wren_a && !c_RDW_OLD) ? w_merge_a : w_old_a;
            w_qb_d   = (wren_b && !c_RDW_OLD) ? w_merge_b : w_old_b;
            w_coll_d = wren_a && wren_b && (address_a == address_b)
                       && (|(byteena_a & byteena_b));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= S_CLEAR;
            r_cnt_q   <= '0;
            r_qa_q    <= '0;
            r_qb_q    <= '0;
            r_coll_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_qa_q    <= w_qa_d;
            r_qb_q    <= w_qb_d;
            r_coll_q  <= w_coll_d;
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic [WIDTH-1:0] r_qa2_q;
            logic [WIDTH-1:0] r_qb2_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_qa2_q <= '0;
                    r_qb2_q <= '0;
                end else begin
                    r_qa2_q <= r_qa_q;
                    r_qb2_q <= r_qb_q;
                end
            end
            assign q_a = r_qa2_q;
            assign q_b = r_qb2_q;
        end else begin : g_no_outreg
            assign q_a = r_qa_q;
            assign q_b = r_qb_q;
        end
    endgenerate

    assign busy      = (r_state_q == S_CLEAR);
    assign collision = r_coll_q;

endmodule

`default_nettype wire

// File: tb/tb_dpram_be_clr.sv
// ============================================================================
// Module   : tb_dpram_be_clr
// Brief    : Directed bench driving three dpram_be_clr variants in lockstep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dpram_be_clr;

    localparam logic [15:0] c_CV = 16'hA5A5;

    logic        clk;
    logic        reset, clear;
    logic [3:0]  address_a, address_b;
    logic [15:0] data_a, data_b;
    logic        wren_a, wren_b;
    logic [1:0]  byteena_a, byteena_b;

    logic        busy0, busy1, busy2;
    logic        coll0, coll1, coll2;
    logic [15:0] q_a0, q_b0, q_a1, q_b1, q_a2, q_b2;

    int n_checks = 0;
    int n_fail   = 0;

    dpram_be_clr #(.WIDTH(16), .ADDR_BITS(4), .OUTREG(0), .RDW_MODE(0), .CLEAR_VALUE(c_CV)) u_new (
        .clock(clk), .reset(reset), .clear(clear), .busy(busy0),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a), .q_a(q_a0),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b), .q_b(q_b0),
        .collision(coll0));

    dpram_be_clr #(.WIDTH(16), .ADDR_BITS(4), .OUTREG(0), .RDW_MODE(1), .CLEAR_VALUE(c_CV)) u_old (
        .clock(clk), .reset(reset), .clear(clear), .busy(busy1),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a), .q_a(q_a1),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b), .q_b(q_b1),
        .collision(coll1));

    dpram_be_clr #(.WIDTH(16), .ADDR_BITS(4), .OUTREG(1), .RDW_MODE(0), .CLEAR_VALUE(c_CV)) u_reg (
        .clock(clk), .reset(reset), .clear(clear), .busy(busy2),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a), .q_a(q_a2),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b), .q_b(q_b2),
        .collision(coll2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 16) begin n_fail++; $display("FAIL %s busy_len: got %0d expected 16", name, n); end
        n_checks++;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL %s busy_outreg: got %b expected 0", name, busy2); end
    endtask

    task automatic read_all_clear(input string name);
        for (int a = 0; a < 16; a++) begin
            address_a = 4'(a);
            address_b = 4'(15 - a);
            tick();
            n_checks++;
            if (q_a0 !== c_CV) begin n_fail++; $display("FAIL %s qa[%0d]: got %h expected %h", name, a, q_a0, c_CV); end
            n_checks++;
            if (q_b1 !== c_CV) begin n_fail++; $display("FAIL %s qb[%0d]: got %h expected %h", name, 15 - a, q_b1, c_CV); end
        end
    endtask

    task automatic test_reset();
        int n;
        tick();
        n_checks++;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy0); end
        n_checks++;
        if (q_a0 !== 16'h0 || q_b0 !== 16'h0) begin n_fail++; $display("FAIL reset_q: got %h/%h expected 0000/0000", q_a0, q_b0); end
        n_checks++;
        if (q_a2 !== 16'h0 || coll0 !== 1'b0) begin n_fail++; $display("FAIL reset_q2_coll: got %h/%b expected 0000/0", q_a2, coll0); end
        reset = 1'b0;
        n = 0;
        // A clear pulse and a port write are injected mid-sequence; both must be ignored.
        while (busy0 === 1'b1 && n < 40) begin
            clear     = (n == 5);
            wren_a    = (n == 10);
            address_a = 4'd0;
            data_a    = 16'h0000;
            byteena_a = 2'b11;
            tick();
            n++;
            n_checks++;
            if (q_a0 !== 16'h0 || q_b0 !== 16'h0 || coll0 !== 1'b0) begin
                n_fail++; $display("FAIL clear_q_zero cyc %0d: got %h/%h/%b expected 0000/0000/0", n, q_a0, q_b0, coll0);
            end
        end
        clear  = 1'b0;
        wren_a = 1'b0;
        n_checks++;
        if (n != 16) begin n_fail++; $display("FAIL busy_len: got %0d expected 16", n); end
    endtask

    task automatic test_byte_write();
        address_a = 4'd3; data_a = 16'h1234; byteena_a = 2'b01; wren_a = 1'b1;
        tick();
        n_checks++;
        if (q_a0 !== 16'hA534) begin n_fail++; $display("FAIL rdw_new: got %h expected a534", q_a0); end
        n_checks++;
        if (q_a1 !== 16'hA5A5) begin n_fail++; $display("FAIL rdw_old: got %h expected a5a5", q_a1); end
        data_a = 16'hFFFF; byteena_a = 2'b00;
        tick();
        n_checks++;
        if (q_a0 !== 16'hA534 || q_a1 !== 16'hA534) begin n_fail++; $display("FAIL be_zero_rdw: got %h/%h expected a534/a534", q_a0, q_a1); end
        wren_a = 1'b0;
        tick();
        n_checks++;
        if (q_a0 !== 16'hA534) begin n_fail++; $display("FAIL byte_readback: got %h expected a534", q_a0); end
    endtask

    task automatic test_collision();
        address_a = 4'd5; data_a = 16'h1111; byteena_a = 2'b11; wren_a = 1'b1;
        address_b = 4'd5; data_b = 16'h2222; byteena_b = 2'b10; wren_b = 1'b1;
        tick();
        n_checks++;
        if (coll0 !== 1'b1 || coll1 !== 1'b1 || coll2 !== 1'b1) begin
            n_fail++; $display("FAIL coll_pulse: got %b%b%b expected 111", coll0, coll1, coll2);
        end
        n_checks++;
        if (q_a0 !== 16'h1111 || q_a1 !== 16'hA5A5) begin n_fail++; $display("FAIL coll_rdw_a: got %h/%h expected 1111/a5a5", q_a0, q_a1); end
        wren_a = 1'b0; wren_b = 1'b0;
        tick();
        n_checks++;
        if (coll0 !== 1'b0 || coll2 !== 1'b0) begin n_fail++; $display("FAIL coll_one_clk: got %b/%b expected 0/0", coll0, coll2); end
        n_checks++;
        if (q_a0 !== 16'h1111) begin n_fail++; $display("FAIL coll_mem: got %h expected 1111", q_a0); end
        byteena_a = 2'b01; wren_a = 1'b1; wren_b = 1'b1;
        tick();
        n_checks++;
        if (coll0 !== 1'b0) begin n_fail++; $display("FAIL disjoint_coll: got %b expected 0", coll0); end
        wren_a = 1'b0; wren_b = 1'b0;
        tick();
        n_checks++;
        if (q_a0 !== 16'h2211 || q_b0 !== 16'h2211) begin n_fail++; $display("FAIL disjoint_mem: got %h/%h expected 2211/2211", q_a0, q_b0); end
    endtask

    task automatic test_cross_port();
        address_a = 4'd7; data_a = 16'hBEEF; byteena_a = 2'b11; wren_a = 1'b1;
        address_b = 4'd7; wren_b = 1'b0;
        tick();
        n_checks++;
        if (q_b0 !== 16'hA5A5 || q_b1 !== 16'hA5A5) begin n_fail++; $display("FAIL cross_old: got %h/%h expected a5a5/a5a5", q_b0, q_b1); end
        wren_a = 1'b0;
        tick();
        n_checks++;
        if (q_b0 !== 16'hBEEF) begin n_fail++; $display("FAIL cross_new: got %h expected beef", q_b0); end
        n_checks++;
        if (q_b2 !== 16'hA5A5) begin n_fail++; $display("FAIL cross_outreg_old: got %h expected a5a5", q_b2); end
        tick();
        n_checks++;
        if (q_b2 !== 16'hBEEF) begin n_fail++; $display("FAIL cross_outreg_new: got %h expected beef", q_b2); end
    endtask

    task automatic test_outreg();
        logic [15:0] exp;
        byteena_a = 2'b11; wren_a = 1'b1;
        for (int a = 0; a < 3; a++) begin
            address_a = 4'(a);
            data_a    = 16'h1000 + 16'(a);
            tick();
        end
        wren_a = 1'b0; address_a = 4'd7;
        tick();
        tick();
        address_a = 4'd2;
        tick();
        n_checks++;
        if (q_a0 !== 16'h1002 || q_a2 !== 16'hBEEF) begin n_fail++; $display("FAIL outreg_lat1: got %h/%h expected 1002/beef", q_a0, q_a2); end
        tick();
        n_checks++;
        if (q_a2 !== 16'h1002) begin n_fail++; $display("FAIL outreg_lat2: got %h expected 1002", q_a2); end
        for (int i = 0; i < 4; i++) begin
            address_a = (i < 3) ? 4'(i) : 4'd2;
            tick();
            if (i > 0) begin
                exp = 16'h1000 + 16'(i - 1);
                n_checks++;
                if (q_a2 !== exp) begin n_fail++; $display("FAIL outreg_stream[%0d]: got %h expected %h", i, q_a2, exp); end
            end
        end
    endtask

    task automatic test_clear_request();
        clear = 1'b1; wren_a = 1'b1; address_a = 4'd0; data_a = 16'h5555; byteena_a = 2'b11;
        tick();
        clear = 1'b0; wren_a = 1'b0;
        n_checks++;
        if (busy0 !== 1'b1 || busy2 !== 1'b1) begin n_fail++; $display("FAIL clear_req_busy: got %b/%b expected 1/1", busy0, busy2); end
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy("reclear");
        read_all_clear("reclear_fill");
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        address_a = '0; data_a = '0; wren_a = 1'b0; byteena_a = '0;
        address_b = '0; data_b = '0; wren_b = 1'b0; byteena_b = '0;
        test_reset();
        read_all_clear("fill");
        test_byte_write();
        test_collision();
        test_cross_port();
        test_outreg();
        test_clear_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
